// File: rtl/rf_pkg.sv
// Defaults shared by the register file and the decode/writeback stages that size against it.
package rf_pkg;

    localparam int unsigned RfDataW = 19;
    localparam int unsigned RfDepth = 8;

    // Address width for a given depth; at least one bit so the ports never collapse to zero width.
    function automatic int unsigned rf_addr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy tracking: reserve on issue, clear on writeback, flush on squash.
module rf_scoreboard import rf_pkg::*; #(
    parameter int unsigned DEPTH    = RfDepth,
    parameter bit          ZERO_REG = 1'b0,
    localparam int unsigned ADDR_W  = rf_addr_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    input  logic              flush_i,
    output logic [DEPTH-1:0]  busy_o,
    output logic              rsv_ok_o,
    output logic [ADDR_W:0]   busy_count_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [ADDR_W:0]  count_q;
    logic [ADDR_W:0]  count_d;
    logic             rsv_free;
    logic             rsv_zero;

    // A register being written back this cycle can be handed straight to the next producer.
    assign rsv_free = ~busy_q[rsv_addr_i] | (wr_en_i & (wr_addr_i == rsv_addr_i));
    assign rsv_zero = ZERO_REG & (rsv_addr_i == '0);
    assign rsv_ok_o = rsv_en_i & ~flush_i & rsv_free & ~rsv_zero;

    always_comb begin
        busy_d = busy_q;
        if (flush_i) begin
            busy_d = '0;
        end else begin
            if (wr_en_i) begin
                busy_d[wr_addr_i] = 1'b0;
            end
            if (rsv_ok_o) begin
                busy_d[rsv_addr_i] = 1'b1;
            end
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            count_d = count_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            busy_q  <= '0;
            count_q <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
        end
    end

    assign busy_o       = busy_q;
    assign busy_count_o = count_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// Two-read/one-write register file with optional write-through bypass, optional zero register,
// and a busy scoreboard linking decode-time reservations to writeback.
module regfile_scoreboard import rf_pkg::*; #(
    parameter int unsigned DATA_W    = RfDataW,
    parameter int unsigned DEPTH     = RfDepth,
    parameter bit          WR_BYPASS = 1'b1,
    parameter bit          ZERO_REG  = 1'b0,
    localparam int unsigned ADDR_W   = rf_addr_w(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    input  logic [ADDR_W-1:0] rd_addr2_i,
    output logic [DATA_W-1:0] rd_data1_o,
    output logic [DATA_W-1:0] rd_data2_o,
    output logic              rd_busy1_o,
    output logic              rd_busy2_o,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    output logic              rsv_ok_o,
    input  logic              flush_i,
    output logic [ADDR_W:0]   busy_count_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              rsv_ok;
    logic              wr_take;

    logic [ADDR_W-1:0] rd_addr [2];
    logic [DATA_W-1:0] rd_data [2];
    logic              rd_busy [2];

    rf_scoreboard #(
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .wr_en_i      (wr_en_i),
        .wr_addr_i    (wr_addr_i),
        .rsv_en_i     (rsv_en_i),
        .rsv_addr_i   (rsv_addr_i),
        .flush_i      (flush_i),
        .busy_o       (busy),
        .rsv_ok_o     (rsv_ok),
        .busy_count_o (busy_count_o)
    );

    assign rsv_ok_o = rsv_ok;
    assign wr_take  = wr_en_i & ~(ZERO_REG & (wr_addr_i == '0));

    always_comb begin
        mem_d = mem_q;
        if (wr_take) begin
            mem_d[wr_addr_i] = wr_data_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rd_addr[0] = rd_addr1_i;
    assign rd_addr[1] = rd_addr2_i;

    // Bypassed reads see the incoming value, so they are only busy if a new producer claims it now.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = mem_q[rd_addr[p]];
            rd_busy[p] = busy[rd_addr[p]];
            if (WR_BYPASS && wr_take && (rd_addr[p] == wr_addr_i)) begin
                rd_data[p] = wr_data_i;
                rd_busy[p] = rsv_ok & (rsv_addr_i == wr_addr_i);
            end
            if (ZERO_REG && (rd_addr[p] == '0)) begin
                rd_data[p] = '0;
                rd_busy[p] = 1'b0;
            end
        end
    end

    assign rd_data1_o = rd_data[0];
    assign rd_data2_o = rd_data[1];
    assign rd_busy1_o = rd_busy[0];
    assign rd_busy2_o = rd_busy[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Drives three register-file configurations (bypass, no bypass, zero register) from one stimulus
// stream and checks each against an array-based model of the register/busy rules.
module tb_regfile_scoreboard;

    localparam int unsigned DW   = 19;
    localparam int unsigned AW   = 3;
    localparam int          NCFG = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, rsv_addr;
    logic [DW-1:0] wr_data;
    logic          wr_en, rsv_en, flush;

    logic [DW-1:0] rd_data1   [NCFG];
    logic [DW-1:0] rd_data2   [NCFG];
    logic          rd_busy1   [NCFG];
    logic          rd_busy2   [NCFG];
    logic          rsv_ok     [NCFG];
    logic [AW:0]   busy_count [NCFG];

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] m_mem  [NCFG][8];
    bit            m_busy [NCFG][8];

    always #10 clk = ~clk;

    regfile_scoreboard #(.DATA_W(DW), .DEPTH(8), .WR_BYPASS(1'b1), .ZERO_REG(1'b0)) u_byp (
        .clk_i(clk), .reset_i(reset), .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
        .rd_data1_o(rd_data1[0]), .rd_data2_o(rd_data2[0]), .rd_busy1_o(rd_busy1[0]),
        .rd_busy2_o(rd_busy2[0]), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .rsv_ok_o(rsv_ok[0]), .flush_i(flush),
        .busy_count_o(busy_count[0]));

    regfile_scoreboard #(.DATA_W(DW), .DEPTH(8), .WR_BYPASS(1'b0), .ZERO_REG(1'b0)) u_nobyp (
        .clk_i(clk), .reset_i(reset), .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
        .rd_data1_o(rd_data1[1]), .rd_data2_o(rd_data2[1]), .rd_busy1_o(rd_busy1[1]),
        .rd_busy2_o(rd_busy2[1]), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .rsv_ok_o(rsv_ok[1]), .flush_i(flush),
        .busy_count_o(busy_count[1]));

    regfile_scoreboard #(.DATA_W(DW), .DEPTH(8), .WR_BYPASS(1'b1), .ZERO_REG(1'b1)) u_zero (
        .clk_i(clk), .reset_i(reset), .rd_addr1_i(rd_addr1), .rd_addr2_i(rd_addr2),
        .rd_data1_o(rd_data1[2]), .rd_data2_o(rd_data2[2]), .rd_busy1_o(rd_busy1[2]),
        .rd_busy2_o(rd_busy2[2]), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .rsv_ok_o(rsv_ok[2]), .flush_i(flush),
        .busy_count_o(busy_count[2]));

    // ---------------- reference model ----------------
    function automatic bit cfg_byp(input int c);
        return c != 1;
    endfunction

    function automatic bit cfg_zr(input int c);
        return c == 2;
    endfunction

    function automatic bit m_rsv_ok(input int c);
        if (!rsv_en || flush) return 1'b0;
        if (cfg_zr(c) && rsv_addr == 3'd0) return 1'b0;
        return !m_busy[c][rsv_addr] || (wr_en && wr_addr == rsv_addr);
    endfunction

    function automatic logic [DW-1:0] m_rd(input int c, input logic [AW-1:0] a);
        if (cfg_zr(c) && a == 3'd0) return '0;
        if (cfg_byp(c) && wr_en && a == wr_addr) return wr_data;
        return m_mem[c][a];
    endfunction

    function automatic bit m_rbusy(input int c, input logic [AW-1:0] a);
        if (cfg_zr(c) && a == 3'd0) return 1'b0;
        if (cfg_byp(c) && wr_en && a == wr_addr) return m_rsv_ok(c) && rsv_addr == a;
        return m_busy[c][a];
    endfunction

    function automatic int m_cnt(input int c);
        int n = 0;
        for (int a = 0; a < 8; a++) n += int'(m_busy[c][a]);
        return n;
    endfunction

    task automatic m_reset();
        for (int c = 0; c < NCFG; c++) begin
            for (int a = 0; a < 8; a++) begin
                m_mem[c][a]  = '0;
                m_busy[c][a] = 1'b0;
            end
        end
    endtask

    task automatic m_edge();
        bit ok;
        if (reset) begin
            m_reset();
            return;
        end
        for (int c = 0; c < NCFG; c++) begin
            ok = m_rsv_ok(c);
            if (wr_en && !(cfg_zr(c) && wr_addr == 3'd0)) m_mem[c][wr_addr] = wr_data;
            if (flush) begin
                for (int a = 0; a < 8; a++) m_busy[c][a] = 1'b0;
            end else begin
                if (wr_en) m_busy[c][wr_addr] = 1'b0;
                if (ok) m_busy[c][rsv_addr] = 1'b1;
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic drv(input bit we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit re, input logic [AW-1:0] ra, input bit fl,
                       input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        @(negedge clk);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        rsv_en   = re;
        rsv_addr = ra;
        flush    = fl;
        rd_addr1 = a1;
        rd_addr2 = a2;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0;
        wr_addr = '0; rsv_addr = '0; wr_data = '0;
        m_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rd_addr1 = 3'(a);
            rd_addr2 = 3'(7 - a);
            #1;
            for (int c = 0; c < NCFG; c++) begin
                if ({rd_data1[c], rd_data2[c], rd_busy1[c], rd_busy2[c], busy_count[c]} !== '0) begin
                    n_err++;
                    $display("FAIL reset cfg%0d addr%0d: got data %h/%h busy %b/%b cnt %0d, want all 0",
                             c, a, rd_data1[c], rd_data2[c], rd_busy1[c], rd_busy2[c], busy_count[c]);
                end
                n_vec++;
            end
        end
    endtask

    task automatic test_write_read();
        logic [DW-1:0] want;
        drv(1'b1, 3'd3, 19'h5A5A5, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        tick();
        drv(1'b0, 3'd0, 19'h0, 1'b0, 3'd0, 1'b0, 3'd3, 3'd3);
        for (int c = 0; c < NCFG; c++) begin
            if (rd_data1[c] !== 19'h5A5A5 || rd_data2[c] !== 19'h5A5A5) begin
                n_err++;
                $display("FAIL write_read_r3 cfg%0d: got %h/%h, want 5a5a5", c, rd_data1[c], rd_data2[c]);
            end
            n_vec++;
        end
        tick();
        drv(1'b1, 3'd7, 19'h7FFFF, 1'b0, 3'd0, 1'b0, 3'd7, 3'd7);
        for (int c = 0; c < NCFG; c++) begin
            want = (c == 1) ? 19'h0 : 19'h7FFFF;
            if (rd_data1[c] !== want || rd_data2[c] !== want) begin
                n_err++;
                $display("FAIL bypass_r7 cfg%0d: got %h/%h, want %h", c, rd_data1[c], rd_data2[c], want);
            end
            n_vec++;
        end
        tick();
        drv(1'b0, 3'd0, 19'h0, 1'b0, 3'd0, 1'b0, 3'd7, 3'd7);
        for (int c = 0; c < NCFG; c++) begin
            if (rd_data1[c] !== 19'h7FFFF || rd_data2[c] !== 19'h7FFFF) begin
                n_err++;
                $display("FAIL after_write_r7 cfg%0d: got %h/%h, want 7ffff", c, rd_data1[c], rd_data2[c]);
            end
            n_vec++;
        end
        tick();
    endtask

    task automatic test_reserve();
        logic [DW-1:0] want_d;
        bit            want_b;
        drv(1'b0, 3'd0, 19'h0, 1'b1, 3'd2, 1'b0, 3'd2, 3'd2);
        for (int c = 0; c < NCFG; c++) begin
            if (rsv_ok[c] !== 1'b1) begin
                n_err++;
                $display("FAIL rsv_r2 cfg%0d: got rsv_ok %b, want 1", c, rsv_ok[c]);
            end
            n_vec++;
        end
        tick();
        drv(1'b0, 3'd0, 19'h0, 1'b1, 3'd2, 1'b0, 3'd2, 3'd2);
        for (int c = 0; c < NCFG; c++) begin
            if (rsv_ok[c] !== 1'b0 || rd_busy1[c] !== 1'b1 || rd_busy2[c] !== 1'b1 ||
                busy_count[c] !== 4'd1) begin
                n_err++;
                $display("FAIL rsv_r2_again cfg%0d: got ok %b busy %b/%b cnt %0d, want 0 1/1 1",
                         c, rsv_ok[c], rd_busy1[c], rd_busy2[c], busy_count[c]);
            end
            n_vec++;
        end
        tick();
        drv(1'b1, 3'd2, 19'h00042, 1'b0, 3'd0, 1'b0, 3'd2, 3'd2);
        for (int c = 0; c < NCFG; c++) begin
            want_d = (c == 1) ? 19'h0 : 19'h00042;
            want_b = (c == 1);
            if (rd_data1[c] !== want_d || rd_busy1[c] !== want_b || busy_count[c] !== 4'd1) begin
                n_err++;
                $display("FAIL wb_r2 cfg%0d: got %h busy %b cnt %0d, want %h busy %b cnt 1",
                         c, rd_data1[c], rd_busy1[c], busy_count[c], want_d, want_b);
            end
            n_vec++;
        end
        tick();
        drv(1'b0, 3'd0, 19'h0, 1'b0, 3'd0, 1'b0, 3'd2, 3'd2);
        for (int c = 0; c < NCFG; c++) begin
            if (rd_data2[c] !== 19'h00042 || rd_busy2[c] !== 1'b0 || busy_count[c] !== 4'd0) begin
                n_err++;
                $display("FAIL after_wb_r2 cfg%0d: got %h busy %b cnt %0d, want 00042 busy 0 cnt 0",
                         c, rd_data2[c], rd_busy2[c], busy_count[c]);
            end
            n_vec++;
        end
        tick();
    endtask

    task automatic test_write_reserve_same();
        drv(1'b0, 3'd0, 19'h0, 1'b1, 3'd4, 1'b0, 3'd4, 3'd4);
        tick();
        drv(1'b1, 3'd4, 19'h00123, 1'b1, 3'd4, 1'b0, 3'd4, 3'd4);
        for (int c = 0; c < NCFG; c++) begin
            if (rsv_ok[c] !== 1'b1 || rd_busy1[c] !== 1'b1 || busy_count[c] !== 4'd1) begin
                n_err++;
                $display("FAIL wr_rsv_r4 cfg%0d: got ok %b busy %b cnt %0d, want 1 1 1",
                         c, rsv_ok[c], rd_busy1[c], busy_count[c]);
            end
            n_vec++;
        end
        tick();
        drv(1'b0, 3'd0, 19'h0, 1'b0, 3'd0, 1'b0, 3'd4, 3'd4);
        for (int c = 0; c < NCFG; c++) begin
            if (rd_data1[c] !== 19'h00123 || rd_busy2[c] !== 1'b1 || busy_count[c] !== 4'd1) begin
                n_err++;
                $display("FAIL after_wr_rsv_r4 cfg%0d: got %h busy %b cnt %0d, want 00123 1 1",
                         c, rd_data1[c], rd_busy2[c], busy_count[c]);
            end
            n_vec++;
        end
        tick();
        drv(1'b1, 3'd4, 19'h00123, 1'b0, 3'd0, 1'b0, 3'd4, 3'd4);
        tick();
    endtask

    task automatic test_flush();
        logic [AW-1:0] regs [3];
        regs[0] = 3'd1; regs[1] = 3'd5; regs[2] = 3'd6;
        for (int i = 0; i < 3; i++) begin
            drv(1'b0, 3'd0, 19'h0, 1'b1, regs[i], 1'b0, regs[i], regs[i]);
            tick();
        end
        drv(1'b0, 3'd0, 19'h0, 1'b1, 3'd0, 1'b1, 3'd3, 3'd4);
        for (int c = 0; c < NCFG; c++) begin
            if (rsv_ok[c] !== 1'b0 || busy_count[c] !== 4'd3) begin
                n_err++;
                $display("FAIL flush_rsv cfg%0d: got ok %b cnt %0d, want ok 0 cnt 3",
                         c, rsv_ok[c], busy_count[c]);
            end
            n_vec++;
        end
        tick();
        drv(1'b0, 3'd0, 19'h0, 1'b0, 3'd0, 1'b0, 3'd3, 3'd4);
        for (int c = 0; c < NCFG; c++) begin
            if (rd_data1[c] !== 19'h5A5A5 || rd_data2[c] !== 19'h00123 || busy_count[c] !== 4'd0) begin
                n_err++;
                $display("FAIL after_flush cfg%0d: got %h/%h cnt %0d, want 5a5a5/00123 cnt 0",
                         c, rd_data1[c], rd_data2[c], busy_count[c]);
            end
            n_vec++;
        end
        for (int a = 0; a < 8; a++) begin
            rd_addr1 = 3'(a);
            rd_addr2 = 3'(a);
            #1;
            for (int c = 0; c < NCFG; c++) begin
                if (rd_busy1[c] !== 1'b0 || rd_busy2[c] !== 1'b0) begin
                    n_err++;
                    $display("FAIL flush_busy cfg%0d r%0d: got %b/%b, want 0/0",
                             c, a, rd_busy1[c], rd_busy2[c]);
                end
                n_vec++;
            end
        end
        tick();
    endtask

    task automatic test_zero_reg();
        logic [DW-1:0] want_d;
        bit            want_b;
        drv(1'b1, 3'd0, 19'h00001, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        for (int c = 0; c < NCFG; c++) begin
            want_d = (c == 0) ? 19'h1 : 19'h0;
            if (rd_data1[c] !== want_d) begin
                n_err++;
                $display("FAIL zero_wr_bypass cfg%0d: got %h, want %h", c, rd_data1[c], want_d);
            end
            n_vec++;
        end
        tick();
        drv(1'b0, 3'd0, 19'h0, 1'b1, 3'd0, 1'b0, 3'd0, 3'd0);
        for (int c = 0; c < NCFG; c++) begin
            want_d = (c == 2) ? 19'h0 : 19'h1;
            want_b = (c != 2);
            if (rd_data2[c] !== want_d || rsv_ok[c] !== want_b) begin
                n_err++;
                $display("FAIL zero_rsv cfg%0d: got %h ok %b, want %h ok %b",
                         c, rd_data2[c], rsv_ok[c], want_d, want_b);
            end
            n_vec++;
        end
        tick();
        drv(1'b0, 3'd0, 19'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        for (int c = 0; c < NCFG; c++) begin
            want_b = (c != 2);
            if (rd_busy1[c] !== want_b || busy_count[c] !== {3'd0, want_b}) begin
                n_err++;
                $display("FAIL zero_busy cfg%0d: got busy %b cnt %0d, want %b",
                         c, rd_busy1[c], busy_count[c], want_b);
            end
            n_vec++;
        end
        tick();
        drv(1'b1, 3'd0, 19'h0, 1'b0, 3'd0, 1'b0, 3'd0, 3'd0);
        tick();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drv(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 19'($urandom),
                1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ($urandom_range(0, 15) == 0),
                3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
            for (int c = 0; c < NCFG; c++) begin
                if (rd_data1[c] !== m_rd(c, rd_addr1) || rd_data2[c] !== m_rd(c, rd_addr2) ||
                    rd_busy1[c] !== m_rbusy(c, rd_addr1) || rd_busy2[c] !== m_rbusy(c, rd_addr2) ||
                    rsv_ok[c] !== m_rsv_ok(c) || busy_count[c] !== 4'(m_cnt(c))) begin
                    n_err++;
                    $display("FAIL random#%0d cfg%0d: got d %h/%h b %b/%b ok %b cnt %0d, want d %h/%h b %b/%b ok %b cnt %0d",
                             n, c, rd_data1[c], rd_data2[c], rd_busy1[c], rd_busy2[c], rsv_ok[c],
                             busy_count[c], m_rd(c, rd_addr1), m_rd(c, rd_addr2),
                             m_rbusy(c, rd_addr1), m_rbusy(c, rd_addr2), m_rsv_ok(c), m_cnt(c));
                end
                n_vec++;
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i < 7; i++) begin
            drv(1'b1, 3'(i), 19'($urandom), 1'b1, 3'(i + 1), 1'b0, 3'd0, 3'd0);
            tick();
        end
        drv(1'b1, 3'd7, 19'h01234, 1'b1, 3'd7, 1'b0, 3'd0, 3'd0);
        #3;
        reset = 1'b1;
        m_reset();
        for (int a = 0; a < 7; a++) begin
            rd_addr1 = 3'(a);
            rd_addr2 = 3'(6 - a);
            #1;
            for (int c = 0; c < NCFG; c++) begin
                if ({rd_data1[c], rd_data2[c], rd_busy1[c], rd_busy2[c], busy_count[c]} !== '0) begin
                    n_err++;
                    $display("FAIL reset_mid cfg%0d addr%0d: got data %h/%h busy %b/%b cnt %0d, want all 0",
                             c, a, rd_data1[c], rd_data2[c], rd_busy1[c], rd_busy2[c], busy_count[c]);
                end
                n_vec++;
            end
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        drv(1'b0, 3'd0, 19'h0, 1'b0, 3'd0, 1'b0, 3'd7, 3'd7);
        for (int c = 0; c < NCFG; c++) begin
            if (rd_data1[c] !== 19'h01234 || rd_busy1[c] !== 1'b1 || busy_count[c] !== 4'd1) begin
                n_err++;
                $display("FAIL post_reset_edge cfg%0d: got %h busy %b cnt %0d, want 01234 1 1",
                         c, rd_data1[c], rd_busy1[c], busy_count[c]);
            end
            n_vec++;
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_reserve();
        test_write_reserve_same();
        test_flush();
        test_zero_reg();
        test_random();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
